// File: rtl/box_attr_ctrl_if.sv
// Signal bundle between the clock/timer core, box_attr_ctrl and the VGA figure generator.
// The slave modport is the attribute controller; the master modport is whatever drives its inputs.
interface box_attr_ctrl_if;
  // Protocol: frame_tick and timer_done are single-cycle pulses; ring_ack is a level
  // that is sampled on every clk edge; edit_sel is a level sampled only on frame_tick.
  // The box colours, ring_on and ring_active are registered and change only on the
  // clk edge where frame_tick is high, holding their value between frame ticks.
  logic       frame_tick;
  logic       timer_done;
  logic       ring_ack;
  logic [1:0] edit_sel;

  logic [7:0] box_h_rgb;
  logic [7:0] box_f_rgb;
  logic [7:0] box_t_rgb;
  logic       ring_on;
  logic       ring_active;

  // Current ring FSM state, exposed for checkers and debug.
  logic [1:0] state_dbg;

  modport master (
    output frame_tick,
    output timer_done,
    output ring_ack,
    output edit_sel,
    input  box_h_rgb,
    input  box_f_rgb,
    input  box_t_rgb,
    input  ring_on,
    input  ring_active,
    input  state_dbg
  );

  modport slave (
    input  frame_tick,
    input  timer_done,
    input  ring_ack,
    input  edit_sel,
    output box_h_rgb,
    output box_f_rgb,
    output box_t_rgb,
    output ring_on,
    output ring_active,
    output state_dbg
  );
endinterface

// File: rtl/box_attr_ctrl.sv
// Frame-synchronous attribute controller for the hour/date/timer boxes: sequences the
// timer ring alert and the edit-cursor blink, updating all attributes only on frame_tick.
module box_attr_ctrl #(
  parameter logic [7:0] BASE_RGB     = 8'h1E,
  parameter logic [7:0] RING_RGB     = 8'hE0,
  parameter logic [7:0] EDIT_RGB     = 8'hFC,
  parameter int         BLINK_FRAMES = 30,
  parameter int         RING_BLINKS  = 10
) (
  input  logic            clk,
  input  logic            reset,
  box_attr_ctrl_if.slave  bus
);

  localparam logic [7:0] BF_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] RB_LAST = 8'(RING_BLINKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RING_ON  = 2'd1,
    RING_OFF = 2'd2
  } state_t;

  state_t     state,        state_n;
  logic [7:0] fcnt,         fcnt_n;
  logic [7:0] bcnt,         bcnt_n;
  logic       req_pend,     req_pend_n;
  logic       ack_pend,     ack_pend_n;
  logic [1:0] esel,         esel_n;
  logic [7:0] ecnt,         ecnt_n;
  logic       ephase,       ephase_n;
  logic [7:0] box_h_q,      box_h_n;
  logic [7:0] box_f_q,      box_f_n;
  logic [7:0] box_t_q,      box_t_n;
  logic       ring_on_q,    ring_on_n;
  logic       ring_active_q, ring_active_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fcnt          <= 8'd0;
      bcnt          <= 8'd0;
      req_pend      <= 1'b0;
      ack_pend      <= 1'b0;
      esel          <= 2'b00;
      ecnt          <= 8'd0;
      ephase        <= 1'b0;
      box_h_q       <= BASE_RGB;
      box_f_q       <= BASE_RGB;
      box_t_q       <= BASE_RGB;
      ring_on_q     <= 1'b0;
      ring_active_q <= 1'b0;
    end else begin
      state         <= state_n;
      fcnt          <= fcnt_n;
      bcnt          <= bcnt_n;
      req_pend      <= req_pend_n;
      ack_pend      <= ack_pend_n;
      esel          <= esel_n;
      ecnt          <= ecnt_n;
      ephase        <= ephase_n;
      box_h_q       <= box_h_n;
      box_f_q       <= box_f_n;
      box_t_q       <= box_t_n;
      ring_on_q     <= ring_on_n;
      ring_active_q <= ring_active_n;
    end
  end

  always_comb begin
    state_n       = state;
    fcnt_n        = fcnt;
    bcnt_n        = bcnt;
    req_pend_n    = req_pend;
    ack_pend_n    = ack_pend;
    esel_n        = esel;
    ecnt_n        = ecnt;
    ephase_n      = ephase;
    box_h_n       = box_h_q;
    box_f_n       = box_f_q;
    box_t_n       = box_t_q;
    ring_on_n     = ring_on_q;
    ring_active_n = ring_active_q;

    // Events are latched every cycle but only acted on at a later frame_tick, so one
    // arriving on the tick itself waits for the next frame.
    if (state == IDLE && bus.timer_done) begin
      req_pend_n = 1'b1;
    end
    if (state != IDLE && bus.ring_ack) begin
      ack_pend_n = 1'b1;
    end

    if (bus.frame_tick) begin
      unique case (state)
        IDLE: begin
          if (req_pend) begin
            state_n    = RING_ON;
            fcnt_n     = 8'd0;
            bcnt_n     = 8'd0;
            req_pend_n = 1'b0;
          end
        end
        RING_ON: begin
          if (ack_pend) begin
            state_n    = IDLE;
            ack_pend_n = 1'b0;
          end else if (fcnt == BF_LAST) begin
            state_n = RING_OFF;
            fcnt_n  = 8'd0;
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
        RING_OFF: begin
          if (ack_pend) begin
            state_n    = IDLE;
            ack_pend_n = 1'b0;
          end else if (fcnt == BF_LAST) begin
            if (bcnt == RB_LAST) begin
              state_n    = IDLE;
              ack_pend_n = 1'b0;
            end else begin
              state_n = RING_ON;
              bcnt_n  = bcnt + 8'd1;
              fcnt_n  = 8'd0;
            end
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
        default: begin
          state_n    = IDLE;
          ack_pend_n = 1'b0;
        end
      endcase

      // A fresh selection (including a switch between boxes) restarts the blink in the OFF phase.
      esel_n = bus.edit_sel;
      if (bus.edit_sel == 2'b00 || bus.edit_sel != esel) begin
        ecnt_n   = 8'd0;
        ephase_n = 1'b0;
      end else if (ecnt == BF_LAST) begin
        ecnt_n   = 8'd0;
        ephase_n = ~ephase;
      end else begin
        ecnt_n = ecnt + 8'd1;
      end

      // Registered outputs reflect the state entered on this tick.
      box_h_n       = (esel_n == 2'b01 && ephase_n) ? EDIT_RGB : BASE_RGB;
      box_f_n       = (esel_n == 2'b10 && ephase_n) ? EDIT_RGB : BASE_RGB;
      if (state_n == RING_ON) begin
        box_t_n = RING_RGB;
      end else begin
        box_t_n = (esel_n == 2'b11 && ephase_n) ? EDIT_RGB : BASE_RGB;
      end
      ring_on_n     = (state_n == RING_ON);
      ring_active_n = (state_n != IDLE);
    end
  end

  assign bus.box_h_rgb   = box_h_q;
  assign bus.box_f_rgb   = box_f_q;
  assign bus.box_t_rgb   = box_t_q;
  assign bus.ring_on     = ring_on_q;
  assign bus.ring_active = ring_active_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_box_attr_ctrl.sv
// Directed bench for box_attr_ctrl with BLINK_FRAMES=2, RING_BLINKS=3 and a 10-clock frame.
module tb_box_attr_ctrl;
  localparam int         BF   = 2;
  localparam int         RB   = 3;
  localparam logic [7:0] BASE = 8'h1E;
  localparam logic [7:0] RING = 8'hE0;
  localparam logic [7:0] EDIT = 8'hFC;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  box_attr_ctrl_if bus ();

  box_attr_ctrl #(
    .BASE_RGB    (BASE),
    .RING_RGB    (RING),
    .EDIT_RGB    (EDIT),
    .BLINK_FRAMES(BF),
    .RING_BLINKS (RB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] h, input logic [7:0] f,
                            input logic [7:0] t, input logic ron, input logic ract);
    check({tag, ".h"},    32'(bus.box_h_rgb),   32'(h));
    check({tag, ".f"},    32'(bus.box_f_rgb),   32'(f));
    check({tag, ".t"},    32'(bus.box_t_rgb),   32'(t));
    check({tag, ".ron"},  32'(bus.ring_on),     32'(ron));
    check({tag, ".ract"}, 32'(bus.ring_active), 32'(ract));
  endtask

  // One 10-clock frame: frame_tick on the first cycle; optional timer_done / ring_ack
  // pulse either mid-frame or coincident with the tick. Returns on a negedge.
  task automatic run_frame(input bit td, input bit ack, input bit at_tick);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.frame_tick = (i == 0);
      bus.timer_done = td  && (at_tick ? (i == 0) : (i == 4));
      bus.ring_ack   = ack && (at_tick ? (i == 0) : (i == 4));
    end
  endtask

  // Ring frame f (1-based) is in the ON phase for the first BF frames of each 2*BF.
  function automatic bit ring_phase_on(input int f);
    return (((f - 1) / BF) % 2) == 0;
  endfunction

  // Edit frame e (1-based since the selection appeared) shows EDIT in odd blink phases.
  function automatic bit edit_phase(input int e);
    return (((e - 1) / BF) % 2) == 1;
  endfunction

  initial begin
    logic [7:0] exp_t;
    logic [7:0] exp_h;
    logic [7:0] exp_f;
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.timer_done = 1'b0;
    bus.ring_ack   = 1'b0;
    bus.edit_sel   = 2'b00;
    repeat (3) @(negedge clk);
    check_outs("rst", BASE, BASE, BASE, 1'b0, 1'b0);
    check("rst.state", 32'(bus.state_dbg), 32'd0);
    reset = 1'b1;

    // Full ring; an extra timer_done in frame 5 must not extend it.
    run_frame(1'b1, 1'b0, 1'b0);
    check_outs("pre_ring", BASE, BASE, BASE, 1'b0, 1'b0);
    for (int f = 1; f <= 14; f++) begin
      bit on;
      bit act;
      act = (f <= 2 * BF * RB);
      on  = act && ring_phase_on(f);
      run_frame(f == 5, 1'b0, 1'b0);
      check_outs($sformatf("ring_f%0d", f), BASE, BASE, on ? RING : BASE, on, act);
    end

    // Ack during frame 3 (OFF phase) ends the ring at the next tick.
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("ack_f1", BASE, BASE, RING, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0);
    check_outs("ack_f3", BASE, BASE, BASE, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("ack_idle", BASE, BASE, BASE, 1'b0, 1'b0);
    // Ack in IDLE is dropped and must not cut short the next ring.
    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    check_outs("idle_ack", BASE, BASE, BASE, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("stale_f1", BASE, BASE, RING, 1'b1, 1'b1);
    run_frame(1'b0, 1'b1, 1'b0);
    check_outs("stale_f2", BASE, BASE, RING, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("stale_stop", BASE, BASE, BASE, 1'b0, 1'b0);

    // Edit blink on the hour box, then release.
    bus.edit_sel = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      run_frame(1'b0, 1'b0, 1'b0);
      exp_h = edit_phase(e) ? EDIT : BASE;
      check_outs($sformatf("edit_h%0d", e), exp_h, BASE, BASE, 1'b0, 1'b0);
    end
    bus.edit_sel = 2'b00;
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("edit_off", BASE, BASE, BASE, 1'b0, 1'b0);

    // Switching hour -> date restarts the blink in the OFF phase.
    bus.edit_sel = 2'b01;
    for (int e = 1; e <= 3; e++) run_frame(1'b0, 1'b0, 1'b0);
    check_outs("sw_h3", EDIT, BASE, BASE, 1'b0, 1'b0);
    bus.edit_sel = 2'b10;
    for (int e = 1; e <= 3; e++) begin
      run_frame(1'b0, 1'b0, 1'b0);
      exp_f = edit_phase(e) ? EDIT : BASE;
      check_outs($sformatf("sw_f%0d", e), BASE, exp_f, BASE, 1'b0, 1'b0);
    end
    bus.edit_sel = 2'b00;
    run_frame(1'b0, 1'b0, 1'b0);

    // Timer box under edit while ringing: ring colour wins only in the ON phase.
    bus.edit_sel = 2'b11;
    run_frame(1'b1, 1'b0, 1'b0);
    check_outs("pri_pre", BASE, BASE, BASE, 1'b0, 1'b0);
    for (int f = 1; f <= 13; f++) begin
      bit on;
      bit act;
      act = (f <= 2 * BF * RB);
      on  = act && ring_phase_on(f);
      run_frame(1'b0, 1'b0, 1'b0);
      exp_t = on ? RING : (edit_phase(f + 1) ? EDIT : BASE);
      check_outs($sformatf("pri_f%0d", f), BASE, BASE, exp_t, on, act);
    end
    bus.edit_sel = 2'b00;
    run_frame(1'b0, 1'b0, 1'b0);

    // timer_done and ring_ack in the same IDLE cycle: ring starts, ack dropped.
    run_frame(1'b1, 1'b1, 1'b0);
    check_outs("both_pre", BASE, BASE, BASE, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("both_f1", BASE, BASE, RING, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("both_f2", BASE, BASE, RING, 1'b1, 1'b1);

    // Asynchronous reset mid-ring.
    #2 reset = 1'b0;
    #1 check_outs("rst_mid", BASE, BASE, BASE, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("rst_after", BASE, BASE, BASE, 1'b0, 1'b0);

    // Events coincident with frame_tick are acted on one frame later.
    run_frame(1'b1, 1'b0, 1'b1);
    check_outs("co_td", BASE, BASE, BASE, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("co_f1", BASE, BASE, RING, 1'b1, 1'b1);
    run_frame(1'b0, 1'b1, 1'b1);
    check_outs("co_ack", BASE, BASE, RING, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    check_outs("co_stop", BASE, BASE, BASE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/box_attr_ctrl.md
Name: box_attr_ctrl

Overview:
- Frame-synchronous attribute controller for the on-screen clock boxes: hour, date and timer.
- Produces the fill colour for each box and the enable for the timer "ring" figure.
- Sequences the ring/blink alert when the timer expires, and the edit-cursor blink on the box being configured.
- Sits between the clock/timer core and the VGA figure generator. All attributes change only at frame boundaries, so no tearing is visible.

Parameters:
- BASE_RGB, 8'h1E, idle fill colour of every box (dark turquoise).
- RING_RGB, 8'hE0, timer box fill during ring ON phase (red).
- EDIT_RGB, 8'hFC, fill of the edited box during edit-blink ON phase (yellow).
- BLINK_FRAMES, 30, frames per blink phase, range 1..255 (0.5 s at 60 Hz).
- RING_BLINKS, 10, ON/OFF pairs per ring before auto-stop, range 1..255.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- frame_tick, input, 1, one-cycle pulse at start of vertical blank.
- timer_done, input, 1, one-cycle pulse when the timer reaches zero.
- ring_ack, input, 1, user acknowledge, level-sensitive, any cycle.
- edit_sel, input, 2, box under edit: 00 none, 01 hour, 10 date, 11 timer.
- box_h_rgb, output, 8, hour box fill.
- box_f_rgb, output, 8, date box fill.
- box_t_rgb, output, 8, timer box fill.
- ring_on, output, 1, enable for the ring figure.
- ring_active, output, 1, high while a ring sequence runs.

Behaviour:
- Reset (reset=0, async): state IDLE; all counters, pending flags and edit phase 0. box_*_rgb=BASE_RGB; ring_on=0; ring_active=0.
- All outputs are registered. They update only on a clk edge where frame_tick=1, and are visible the cycle after frame_tick. ring_active also changes only at those edges.
- Pending flags:
  - req_pend: set by timer_done while IDLE; cleared on IDLE->RING_ON.
  - ack_pend: set by ring_ack while RING_ON/RING_OFF; cleared on any transition to IDLE.
  - ring_ack while IDLE is discarded.
  - timer_done while ringing is ignored; no restart.
- Same-cycle events:
  - timer_done+ring_ack in IDLE: req_pend set, ack dropped.
  - timer_done/ring_ack coincident with frame_tick: flag set this edge, acted on at the next frame_tick.
- FSM transitions (evaluated only when frame_tick=1; fcnt is the 8-bit frame counter, bcnt the 8-bit blink counter):
  - IDLE: if req_pend -> RING_ON, fcnt=0, bcnt=0.
  - RING_ON:
    - ack_pend -> IDLE.
    - else fcnt==BLINK_FRAMES-1 -> RING_OFF, fcnt=0.
    - else fcnt+1.
  - RING_OFF:
    - ack_pend -> IDLE.
    - else fcnt==BLINK_FRAMES-1: bcnt==RING_BLINKS-1 -> IDLE, else bcnt+1, fcnt=0 -> RING_ON.
    - else fcnt+1.
- Outputs by state:
  - RING_ON: ring_on=1, box_t_rgb=RING_RGB.
  - RING_OFF: ring_on=0, box_t_rgb per edit rule.
  - ring_active=1 in RING_ON/RING_OFF.
- Total ring length without ack: 2*BLINK_FRAMES*RING_BLINKS frames.
- Edit blink:
  - edit_sel is sampled at frame_tick into esel.
  - esel==00: ecnt=0, ephase=0.
  - Otherwise ecnt counts frames; at ecnt==BLINK_FRAMES-1 it wraps to 0 and ephase toggles.
  - A change of edit_sel to a different nonzero value resets ecnt=0 and ephase=0.
  - Selected box fill = EDIT_RGB when ephase=1, else BASE_RGB. Unselected boxes show BASE_RGB.
- Priority on timer box: RING_ON colour > edit colour > BASE.
- Reset mid-sequence aborts immediately to reset values; pending flags are lost.
- Between frame_ticks all outputs hold; no combinational path from inputs to outputs.

Test Plan:
- Use BLINK_FRAMES=2, RING_BLINKS=3; frame_tick every 10 clks.
- Reset check: assert reset=0 mid-stream -> all box_*_rgb=8'h1E, ring_on=0, ring_active=0 immediately. Outputs are unchanged by timer_done until the next frame_tick.
- Full ring: timer_done pulse -> at next frame_tick, ring_active=1, ring_on=1, box_t_rgb=8'hE0. Pattern is ON 2 frames / OFF 2 frames, repeated 3 times. After frame 12, ring_active=0 and box_t_rgb=8'h1E.
- Ack mid-ring: ring_ack pulse in frame 3 (RING_OFF) -> IDLE at the next frame_tick; ring_on=0, ring_active=0. A later ring_ack in IDLE has no effect.
- Edit blink: edit_sel=01 -> box_h_rgb alternates 8'h1E (2 frames) / 8'hFC (2 frames); box_f_rgb and box_t_rgb stay 8'h1E. Setting edit_sel=00 returns box_h_rgb to 8'h1E at the next frame_tick.
- Priority and simultaneity:
  - edit_sel=11 with ring running -> box_t_rgb=8'hE0 in RING_ON, edit colour in RING_OFF.
  - timer_done+ring_ack in the same IDLE cycle -> ring starts at the next frame_tick.
  - timer_done during ringing -> sequence length unchanged (12 frames).
